text_ram: RTL and testbench

- Writable, multi-page character buffer feeding the glyph renderer.
- The read side maps a packed character-cell coordinate to a character code with a fixed one-cycle latency.
- The write side lets game logic update text (score, lives, "Ready"/"Game Over") through a valid/ready handshake.
- A built-in clear engine fills pages with the blank character after reset or on request.

---
 rtl/text_ram_pkg.sv | 45 ++++
 rtl/text_ram_mem.sv | 27 ++
 rtl/text_ram.sv | 235 +++++++++++++++++++++++
 tb/tb_text_ram.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/text_ram_pkg.sv
// Shared types, defaults and address helpers for the text RAM.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package text_pkg;

    // Default geometry and blank code of the text buffer
    localparam int         COLS_DEF   = 32;
    localparam int         ROWS_DEF   = 8;
    localparam int         PAGES_DEF  = 2;
    localparam int         CODE_W_DEF = 7;
    localparam logic [6:0] BLANK_DEF  = 7'h20;

    // Controller states: normal operation, single-page clear, full clear
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CLR_PAGE = 2'd1,
        CLR_ALL  = 2'd2
    } state_t;

    // Column field width
    function automatic int col_w(input int cols);
        return $clog2(cols);
    endfunction

    // Row field width
    function automatic int row_w(input int rows);
        return $clog2(rows);
    endfunction

    // Page port width: at least one bit even for a single page
    function automatic int page_w(input int pages);
        return (pages > 1) ? $clog2(pages) : 1;
    endfunction

    // Flat cell address {page, row, col}; pure shifts since every field is a
    // power of two. Caller truncates to its own address width.
    function automatic logic [31:0] cell_addr(input logic [31:0] page,
                                              input logic [31:0] row,
                                              input logic [31:0] col,
                                              input int          rw,
                                              input int          cw);
        return (page << (rw + cw)) | (row << cw) | col;
    endfunction

endpackage

// File: rtl/text_ram_mem.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
// Latency: read data 1 clk after address; read-before-write on collisions.
// Backpressure: none, accepts a write and a read every cycle.
module text_ram_mem #(
    parameter int AW = 9,
    parameter int DW = 7
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdat,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdat
);

    // No reset on the array or read register so it maps onto block RAM
    logic [DW-1:0] r_mem [0:(1<<AW)-1];

    // Write and registered read share one edge; the read sees the old word
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdat;
        end
        o_rdat <= r_mem[i_raddr];
    end

endmodule

// File: rtl/text_ram.sv
// Multi-page character buffer with clear engine; optional cursor auto-increment (TEXT_RAM_AUTOINC_EN).
// Latency: char_code 1 clk after char_xy/rd_page; writes land on the accepting edge.
// Backpressure: wr_ready low while the clear engine runs; clr_req ignored while busy.
module text_ram
    import text_pkg::*;
#(
    parameter int                COLS   = COLS_DEF,
    parameter int                ROWS   = ROWS_DEF,
    parameter int                PAGES  = PAGES_DEF,
    parameter int                CODE_W = CODE_W_DEF,
    parameter logic [CODE_W-1:0] BLANK  = CODE_W'(BLANK_DEF),
    localparam int               CW     = col_w(COLS),
    localparam int               RW     = row_w(ROWS),
    localparam int               PW     = page_w(PAGES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CW+RW-1:0]  char_xy,
    input  logic [PW-1:0]     rd_page,
    output logic [CODE_W-1:0] char_code,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [PW-1:0]     wr_page,
    input  logic [CW-1:0]     wr_col,
    input  logic [RW-1:0]     wr_row,
    input  logic [CODE_W-1:0] wr_char,
    input  logic              clr_req,
    input  logic [PW-1:0]     clr_page,
    output logic              busy
`ifdef TEXT_RAM_AUTOINC_EN
    ,
    input  logic              wr_auto,
    input  logic              cur_load
`endif
);

    // Page address bits actually used (zero for a single page)
    localparam int PB     = $clog2(PAGES);
    localparam int CELL_W = CW + RW;
    localparam int AW     = PB + CELL_W;

    state_t            r_state;
    logic [AW-1:0]     r_cnt;
    logic [PW-1:0]     r_clr_page;
    logic              r_rd_vld;
    logic              r_rd_blank;

    logic [CW-1:0]     w_rd_col;
    logic [RW-1:0]     w_rd_row;
    logic [AW-1:0]     w_rd_addr;
    logic              w_rd_blank_nxt;
    logic [CODE_W-1:0] w_ram_q;

    logic              w_wr_fire;
    logic [PW-1:0]     w_wr_page;
    logic [RW-1:0]     w_wr_row;
    logic [CW-1:0]     w_wr_col;
    logic [AW-1:0]     w_wr_addr;

    logic [AW-1:0]     w_clr_addr;
    logic              w_cnt_page_last;
    logic              w_cnt_all_last;

    logic              w_mem_we;
    logic [AW-1:0]     w_mem_waddr;
    logic [CODE_W-1:0] w_mem_wdat;

    // ------------------------------------------------------------------
    // Handshake / status
    // ------------------------------------------------------------------
    assign busy      = (r_state != IDLE);
    assign wr_ready  = (r_state == IDLE);
    assign w_wr_fire = wr_valid && wr_ready;

    // ------------------------------------------------------------------
    // Read side: char_xy is {col, row}
    // ------------------------------------------------------------------
    assign w_rd_col  = char_xy[CELL_W-1:RW];
    assign w_rd_row  = char_xy[RW-1:0];
    assign w_rd_addr = AW'(cell_addr(32'(rd_page), 32'(w_rd_row), 32'(w_rd_col), RW, CW));

    // A read hitting a page that is mid-clear must show blank even though
    // the RAM still holds stale text for cells not yet reached.
    assign w_rd_blank_nxt = (r_state == CLR_ALL) ||
                            ((r_state == CLR_PAGE) && (rd_page == r_clr_page));

    // ------------------------------------------------------------------
    // Write target: direct fields or the auto-increment cursor
    // ------------------------------------------------------------------
`ifdef TEXT_RAM_AUTOINC_EN
    logic [PW-1:0] r_cur_page;
    logic [RW-1:0] r_cur_row;
    logic [CW-1:0] r_cur_col;
    logic [PW-1:0] w_base_page;
    logic [RW-1:0] w_base_row;
    logic [CW-1:0] w_base_col;
    logic [RW-1:0] w_next_row;
    logic [CW-1:0] w_next_col;

    // A simultaneous load takes priority: the auto write goes to the loaded cell
    assign w_base_page = cur_load ? wr_page : r_cur_page;
    assign w_base_row  = cur_load ? wr_row  : r_cur_row;
    assign w_base_col  = cur_load ? wr_col  : r_cur_col;

    // Column wraps into the next row; row wraps within the same page
    assign w_next_col  = w_base_col + CW'(1);
    assign w_next_row  = (&w_base_col) ? (w_base_row + RW'(1)) : w_base_row;

    assign w_wr_page   = wr_auto ? w_base_page : wr_page;
    assign w_wr_row    = wr_auto ? w_base_row  : wr_row;
    assign w_wr_col    = wr_auto ? w_base_col  : wr_col;

    // Cursor: loaded on cur_load, advanced by accepted auto writes, untouched by clears
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cur_page <= '0;
            r_cur_row  <= '0;
            r_cur_col  <= '0;
        end else if (w_wr_fire && wr_auto) begin
            r_cur_page <= w_base_page;
            r_cur_row  <= w_next_row;
            r_cur_col  <= w_next_col;
        end else if (cur_load) begin
            r_cur_page <= wr_page;
            r_cur_row  <= wr_row;
            r_cur_col  <= wr_col;
        end
    end
`else
    assign w_wr_page = wr_page;
    assign w_wr_row  = wr_row;
    assign w_wr_col  = wr_col;
`endif

    assign w_wr_addr = AW'(cell_addr(32'(w_wr_page), 32'(w_wr_row), 32'(w_wr_col), RW, CW));

    // ------------------------------------------------------------------
    // Clear engine addressing
    // ------------------------------------------------------------------
    // CLR_ALL walks the whole flat array; CLR_PAGE walks only the cell bits
    // under the latched page.
    assign w_cnt_page_last = &r_cnt[CELL_W-1:0];
    assign w_cnt_all_last  = &r_cnt;

    // Clear target address for the current state
    always_comb begin
        w_clr_addr = r_cnt;
        if (r_state == CLR_PAGE) begin
            w_clr_addr = AW'(cell_addr(32'(r_clr_page), 32'(r_cnt[CELL_W-1:CW]),
                                       32'(r_cnt[CW-1:0]), RW, CW));
        end
    end

    // RAM write port arbitration: the clear engine owns the port while busy
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_waddr = w_wr_addr;
        w_mem_wdat  = wr_char;
        if (r_state != IDLE) begin
            w_mem_we    = 1'b1;
            w_mem_waddr = w_clr_addr;
            w_mem_wdat  = BLANK;
        end else if (w_wr_fire) begin
            w_mem_we    = 1'b1;
        end
    end

    // Controller: reset lands in CLR_ALL so the buffer self-initialises
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= CLR_ALL;
            r_cnt      <= '0;
            r_clr_page <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (clr_req) begin
                        r_state    <= CLR_PAGE;
                        r_cnt      <= '0;
                        r_clr_page <= clr_page;
                    end
                end
                CLR_PAGE: begin
                    if (w_cnt_page_last) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + AW'(1);
                    end
                end
                CLR_ALL: begin
                    if (w_cnt_all_last) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + AW'(1);
                    end
                end
                default: begin
                    r_state <= CLR_ALL;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Read-side qualifiers registered alongside the RAM read data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_vld   <= 1'b0;
            r_rd_blank <= 1'b0;
        end else begin
            r_rd_vld   <= 1'b1;
            r_rd_blank <= w_rd_blank_nxt;
        end
    end

    text_ram_mem #(
        .AW (AW),
        .DW (CODE_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (w_mem_waddr),
        .i_wdat  (w_mem_wdat),
        .i_raddr (w_rd_addr),
        .o_rdat  (w_ram_q)
    );

    // The RAM read register has no reset, so zero and blank are applied
    // with registered qualifiers; every term here comes from a flop.
    assign char_code = !r_rd_vld  ? '0    :
                       r_rd_blank ? BLANK : w_ram_q;

endmodule

// File: tb/tb_text_ram.sv
module tb_text_ram;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] char_xy = '0;
    logic       rd_page = 1'b0;
    logic [6:0] char_code;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic       wr_page = 1'b0;
    logic [4:0] wr_col = '0;
    logic [2:0] wr_row = '0;
    logic [6:0] wr_char = '0;
    logic       clr_req = 1'b0;
    logic       clr_page = 1'b0;
    logic       busy;
`ifdef TEXT_RAM_AUTOINC_EN
    logic       wr_auto = 1'b0;
    logic       cur_load = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    text_ram dut (
        .clk       (clk),
        .rst       (rst),
        .char_xy   (char_xy),
        .rd_page   (rd_page),
        .char_code (char_code),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_page   (wr_page),
        .wr_col    (wr_col),
        .wr_row    (wr_row),
        .wr_char   (wr_char),
        .clr_req   (clr_req),
        .clr_page  (clr_page),
        .busy      (busy)
`ifdef TEXT_RAM_AUTOINC_EN
        ,
        .wr_auto   (wr_auto),
        .cur_load  (cur_load)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] col, input logic [2:0] row,
                      input logic pg, output logic [6:0] code);
        char_xy = {col, row};
        rd_page = pg;
        tick();
        code = char_code;
    endtask

    task automatic wr(input logic pg, input logic [4:0] col,
                      input logic [2:0] row, input logic [6:0] ch);
        wr_page  = pg;
        wr_col   = col;
        wr_row   = row;
        wr_char  = ch;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        int errs;
        logic [6:0] c;
        rst = 1'b0;
        tick();
        tick();
        checks++; if (char_code !== 7'h00) begin failures++; $display("FAIL reset_char_code got=%h exp=00", char_code); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b exp=1", busy); end
        checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL reset_wr_ready got=%b exp=0", wr_ready); end
        rst = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        checks++; if (n != 512) begin failures++; $display("FAIL init_clear_len got=%0d exp=512", n); end
        checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL idle_wr_ready got=%b exp=1", wr_ready); end
        errs = 0;
        for (int p = 0; p < 2; p++)
            for (int r = 0; r < 8; r++)
                for (int cc = 0; cc < 32; cc++) begin
                    rd(5'(cc), 3'(r), 1'(p), c);
                    if (c !== 7'h20) errs++;
                end
        checks++; if (errs != 0) begin failures++; $display("FAIL init_blank_scan bad_cells=%0d exp=0", errs); end
    endtask

    task automatic test_write_read();
        logic [6:0] c;
        wr(1'b0, 5'd5, 3'd0, 7'h52);
        rd(5'd5, 3'd0, 1'b0, c);
        checks++; if (c !== 7'h52) begin failures++; $display("FAIL wr_rd_p0 got=%h exp=52", c); end
        rd(5'd5, 3'd0, 1'b1, c);
        checks++; if (c !== 7'h20) begin failures++; $display("FAIL wr_rd_p1 got=%h exp=20", c); end
    endtask

    task automatic test_collision();
        logic [6:0] c;
        char_xy  = {5'd31, 3'd7};
        rd_page  = 1'b0;
        wr_page  = 1'b0;
        wr_col   = 5'd31;
        wr_row   = 3'd7;
        wr_char  = 7'h41;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        checks++; if (char_code !== 7'h20) begin failures++; $display("FAIL collide_old got=%h exp=20", char_code); end
        rd(5'd31, 3'd7, 1'b0, c);
        checks++; if (c !== 7'h41) begin failures++; $display("FAIL collide_new got=%h exp=41", c); end
    endtask

    task automatic test_clear_page();
        int n;
        int errs_rd;
        int errs_rdy;
        int errs;
        logic [6:0] c;
        logic [6:0] e;
        for (int r = 0; r < 8; r++)
            for (int cc = 0; cc < 32; cc++)
                wr(1'b1, 5'(cc), 3'(r), 7'h58);
        rd(5'd7, 3'd3, 1'b1, c);
        checks++; if (c !== 7'h58) begin failures++; $display("FAIL fill_p1 got=%h exp=58", c); end
        clr_page = 1'b1;
        clr_req  = 1'b1;
        tick();
        clr_req  = 1'b0;
        wr_page  = 1'b1;
        wr_col   = 5'd2;
        wr_row   = 3'd2;
        wr_char  = 7'h32;
        wr_valid = 1'b1;
        n = 0;
        errs_rd = 0;
        errs_rdy = 0;
        while (busy === 1'b1 && n < 1000) begin
            if (wr_ready !== 1'b0) errs_rdy++;
            char_xy = {5'(n % 32), 3'((n / 32) % 8)};
            rd_page = 1'b1;
            if (n == 50) begin
                clr_req  = 1'b1;
                clr_page = 1'b0;
            end else begin
                clr_req  = 1'b0;
            end
            tick();
            n++;
            if (char_code !== 7'h20) errs_rd++;
        end
        clr_req = 1'b0;
        checks++; if (n != 256) begin failures++; $display("FAIL page_clear_len got=%0d exp=256", n); end
        checks++; if (errs_rd != 0) begin failures++; $display("FAIL read_during_clear bad_reads=%0d exp=0", errs_rd); end
        checks++; if (errs_rdy != 0) begin failures++; $display("FAIL ready_during_clear bad_cycles=%0d exp=0", errs_rdy); end
        checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL ready_after_clear got=%b exp=1", wr_ready); end
        tick();
        wr_valid = 1'b0;
        errs = 0;
        for (int r = 0; r < 8; r++)
            for (int cc = 0; cc < 32; cc++) begin
                rd(5'(cc), 3'(r), 1'b1, c);
                e = (r == 2 && cc == 2) ? 7'h32 : 7'h20;
                if (c !== e) errs++;
            end
        checks++; if (errs != 0) begin failures++; $display("FAIL p1_after_clear bad_cells=%0d exp=0", errs); end
        rd(5'd5, 3'd0, 1'b0, c);
        checks++; if (c !== 7'h52) begin failures++; $display("FAIL p0_kept_a got=%h exp=52", c); end
        rd(5'd31, 3'd7, 1'b0, c);
        checks++; if (c !== 7'h41) begin failures++; $display("FAIL p0_kept_b got=%h exp=41", c); end
        rd(5'd0, 3'd0, 1'b0, c);
        checks++; if (c !== 7'h20) begin failures++; $display("FAIL p0_kept_c got=%h exp=20", c); end
    endtask

    task automatic test_reset_mid_clear();
        int n;
        logic [6:0] c;
        rd(5'd5, 3'd0, 1'b0, c);
        checks++; if (c !== 7'h52) begin failures++; $display("FAIL pre_reset_read got=%h exp=52", c); end
        rst = 1'b0;
        #1;
        checks++; if (char_code !== 7'h00) begin failures++; $display("FAIL async_rst_code got=%h exp=00", char_code); end
        checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL async_rst_ready got=%b exp=0", wr_ready); end
        tick();
        rst = 1'b1;
        for (int i = 0; i < 100; i++) tick();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_clear_busy got=%b exp=1", busy); end
        checks++; if (char_code !== 7'h20) begin failures++; $display("FAIL mid_clear_blank got=%h exp=20", char_code); end
        rst = 1'b0;
        #1;
        checks++; if (char_code !== 7'h00) begin failures++; $display("FAIL mid_rst_code got=%h exp=00", char_code); end
        tick();
        tick();
        checks++; if (char_code !== 7'h00) begin failures++; $display("FAIL held_rst_code got=%h exp=00", char_code); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL held_rst_busy got=%b exp=1", busy); end
        rst = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        checks++; if (n != 512) begin failures++; $display("FAIL restart_clear_len got=%0d exp=512", n); end
        rd(5'd5, 3'd0, 1'b0, c);
        checks++; if (c !== 7'h20) begin failures++; $display("FAIL post_restart_read got=%h exp=20", c); end
    endtask

`ifdef TEXT_RAM_AUTOINC_EN
    task automatic test_autoinc();
        logic [6:0] c;
        wr_page  = 1'b0;
        wr_row   = 3'd2;
        wr_col   = 5'd30;
        cur_load = 1'b1;
        tick();
        cur_load = 1'b0;
        wr_page  = 1'b1;
        wr_row   = 3'd0;
        wr_col   = 5'd0;
        wr_auto  = 1'b1;
        wr_valid = 1'b1;
        wr_char  = 7'h41;
        tick();
        wr_char  = 7'h42;
        tick();
        wr_char  = 7'h43;
        tick();
        wr_valid = 1'b0;
        wr_auto  = 1'b0;
        rd(5'd30, 3'd2, 1'b0, c);
        checks++; if (c !== 7'h41) begin failures++; $display("FAIL auto_A got=%h exp=41", c); end
        rd(5'd31, 3'd2, 1'b0, c);
        checks++; if (c !== 7'h42) begin failures++; $display("FAIL auto_B got=%h exp=42", c); end
        rd(5'd0, 3'd3, 1'b0, c);
        checks++; if (c !== 7'h43) begin failures++; $display("FAIL auto_C got=%h exp=43", c); end
        rd(5'd0, 3'd0, 1'b1, c);
        checks++; if (c !== 7'h20) begin failures++; $display("FAIL auto_fields_ignored got=%h exp=20", c); end
        wr_page  = 1'b1;
        wr_row   = 3'd4;
        wr_col   = 5'd10;
        cur_load = 1'b1;
        wr_auto  = 1'b1;
        wr_valid = 1'b1;
        wr_char  = 7'h44;
        tick();
        cur_load = 1'b0;
        wr_char  = 7'h45;
        tick();
        wr_valid = 1'b0;
        wr_auto  = 1'b0;
        rd(5'd10, 3'd4, 1'b1, c);
        checks++; if (c !== 7'h44) begin failures++; $display("FAIL load_and_write got=%h exp=44", c); end
        rd(5'd11, 3'd4, 1'b1, c);
        checks++; if (c !== 7'h45) begin failures++; $display("FAIL after_load_inc got=%h exp=45", c); end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_collision();
        test_clear_page();
        test_reset_mid_clear();
`ifdef TEXT_RAM_AUTOINC_EN
        test_autoinc();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
